// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB3 initiator, one command in flight, valid/ready
// request and response channels, programmable ACCESS watchdog.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_to_q, rsp_to_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    unique case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = REQ_WRITE;
          paddr_d  = REQ_ADDR;
          pwdata_d = REQ_WRITE ? REQ_WDATA : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        // completion has priority over the watchdog on the last cycle
        if (PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          rsp_to_d    = 1'b0;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  // gated by reset so every output reads 0 while PRESETN is low
  assign REQ_READY   = (state_q == IDLE) && PRESETN;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_ERR     = rsp_err_q;
  assign RSP_TIMEOUT = rsp_to_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized and directed checks of apb_cmd_master
// against a transaction-level expectation model.
module tb_apb_cmd_master;

  localparam int TO = 16;

  logic        PCLK;
  logic        PRESETN;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [7:0]  REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int total = 0;
  int bad   = 0;

  apb_cmd_master #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESETN(PRESETN),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID),
    .RSP_READY(RSP_READY),
    .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR),
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1, "bench hang");
  end

  // One full transfer. Expectations come from the transaction rules:
  // ACCESS length = waits+1, or TO when the slave stalls TO+ cycles.
  task automatic run_xfer(
    input bit          wr,
    input logic [7:0]  a,
    input logic [31:0] wd,
    input int          waits,
    input bit          serr,
    input logic [31:0] rd,
    input int          hold
  );
    bit          to;
    int          exp_acc;
    logic [31:0] exp_pw;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          acc;
    bit          unstable;
    to      = (waits >= TO);
    exp_acc = to ? TO : waits + 1;
    exp_pw  = wr ? wd : 32'h0;
    exp_rd  = (wr || to) ? 32'h0 : rd;
    exp_err = to || serr;

    @(negedge PCLK);
    total++;
    if (REQ_READY !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready got=%b exp=1", REQ_READY);
    end
    REQ_VALID = 1'b1;
    REQ_WRITE = wr;
    REQ_ADDR  = a;
    REQ_WDATA = wd;

    @(negedge PCLK);
    REQ_VALID = 1'b0;
    REQ_WRITE = 1'($urandom);
    REQ_ADDR  = 8'($urandom);
    REQ_WDATA = $urandom;
    total++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== wr ||
        PADDR !== a || PWDATA !== exp_pw || REQ_READY !== 1'b0) begin
      bad++;
      $display("FAIL setup got sel=%b en=%b wr=%b a=%h d=%h rdy=%b exp 1 0 %b %h %h 0",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, REQ_READY, wr, a, exp_pw);
    end

    @(negedge PCLK);
    acc = 0;
    unstable = 1'b0;
    while (PSEL === 1'b1 && PENABLE === 1'b1 && acc < 64) begin
      acc++;
      if (PADDR !== a || PWDATA !== exp_pw || PWRITE !== wr ||
          RSP_VALID !== 1'b0 || REQ_READY !== 1'b0)
        unstable = 1'b1;
      PREADY  = (acc == waits + 1);
      PSLVERR = PREADY ? serr : 1'($urandom);
      PRDATA  = PREADY ? rd : $urandom;
      @(negedge PCLK);
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;

    total++;
    if (acc !== exp_acc) begin
      bad++;
      $display("FAIL access_len got=%0d exp=%0d", acc, exp_acc);
    end
    total++;
    if (unstable) begin
      bad++;
      $display("FAIL access_stable got=unstable exp=stable");
    end
    total++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || RSP_VALID !== 1'b1) begin
      bad++;
      $display("FAIL resp_state got sel=%b en=%b v=%b exp 0 0 1",
               PSEL, PENABLE, RSP_VALID);
    end
    total++;
    if (RSP_RDATA !== exp_rd || RSP_ERR !== exp_err ||
        RSP_TIMEOUT !== to) begin
      bad++;
      $display("FAIL resp_fields got d=%h e=%b t=%b exp d=%h e=%b t=%b",
               RSP_RDATA, RSP_ERR, RSP_TIMEOUT, exp_rd, exp_err, to);
    end

    for (int i = 0; i < hold; i++) begin
      REQ_VALID = 1'b1;
      REQ_WRITE = 1'($urandom);
      REQ_ADDR  = 8'($urandom);
      @(negedge PCLK);
      total++;
      if (RSP_VALID !== 1'b1 || RSP_RDATA !== exp_rd ||
          RSP_ERR !== exp_err || RSP_TIMEOUT !== to ||
          REQ_READY !== 1'b0 || PSEL !== 1'b0) begin
        bad++;
        $display("FAIL resp_hold got v=%b d=%h e=%b t=%b rdy=%b sel=%b exp 1 %h %b %b 0 0",
                 RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
                 REQ_READY, PSEL, exp_rd, exp_err, to);
      end
    end
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    @(negedge PCLK);
    RSP_READY = 1'b0;
    total++;
    if (RSP_VALID !== 1'b0 || PSEL !== 1'b0) begin
      bad++;
      $display("FAIL rsp_consume got v=%b sel=%b exp 0 0", RSP_VALID, PSEL);
    end
  endtask

  task automatic test_reset;
    PRESETN   = 1'b0;
    REQ_VALID = 1'b0;
    REQ_WRITE = 1'b0;
    REQ_ADDR  = '0;
    REQ_WDATA = '0;
    RSP_READY = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    #3;
    total++;
    if ({REQ_READY, RSP_VALID, RSP_ERR, RSP_TIMEOUT,
         PSEL, PENABLE, PWRITE} !== 7'b0 ||
        RSP_RDATA !== 32'h0 || PADDR !== 8'h0 || PWDATA !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b v=%b sel=%b en=%b a=%h exp all 0",
               REQ_READY, RSP_VALID, PSEL, PENABLE, PADDR);
    end
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    @(negedge PCLK);
    total++;
    if (REQ_READY !== 1'b1 || PSEL !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got rdy=%b sel=%b exp 1 0", REQ_READY, PSEL);
    end
  endtask

  task automatic test_directed;
    run_xfer(1'b1, 8'h04, 32'h0000_00A5, 0, 1'b0, 32'hDEAD_BEEF, 0);
    run_xfer(1'b0, 8'h80, 32'h1234_5678, 3, 1'b0, 32'h0000_000F, 1);
    run_xfer(1'b1, 8'h10, 32'h5555_AAAA, 2, 1'b1, 32'h0, 0);
    run_xfer(1'b0, 8'h20, 32'h0, 100, 1'b0, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_timeout_edge;
    run_xfer(1'b0, 8'h33, 32'h0, TO - 1, 1'b1, 32'hCAFE_F00D, 0);
    run_xfer(1'b0, 8'h34, 32'h0, TO, 1'b0, 32'hCAFE_F00D, 0);
  endtask

  task automatic test_back_to_back;
    run_xfer(1'b1, 8'h40, 32'h0BAD_CAFE, 1, 1'b0, 32'h0, 5);
    run_xfer(1'b0, 8'h41, 32'h0, 0, 1'b0, 32'h1357_9BDF, 5);
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      run_xfer(1'($urandom), 8'($urandom), $urandom,
               int'($urandom_range(0, 20)), 1'($urandom),
               $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid;
    bit leaked;
    @(negedge PCLK);
    REQ_VALID = 1'b1;
    REQ_WRITE = 1'b0;
    REQ_ADDR  = 8'h55;
    @(negedge PCLK);
    REQ_VALID = 1'b0;
    @(negedge PCLK);
    total++;
    if (PENABLE !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got en=%b exp=1", PENABLE);
    end
    #2;
    PRESETN = 1'b0;
    #1;
    total++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || RSP_VALID !== 1'b0) begin
      bad++;
      $display("FAIL mid_async got sel=%b en=%b v=%b exp 0 0 0",
               PSEL, PENABLE, RSP_VALID);
    end
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    PREADY  = 1'b1;
    leaked  = 1'b0;
    repeat (6) begin
      @(negedge PCLK);
      if (RSP_VALID !== 1'b0 || PSEL !== 1'b0) leaked = 1'b1;
    end
    PREADY = 1'b0;
    total++;
    if (leaked) begin
      bad++;
      $display("FAIL mid_no_resp got=activity exp=quiet");
    end
    run_xfer(1'b0, 8'h56, 32'h0, 1, 1'b0, 32'h2468_ACE0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout_edge();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
